// File: rtl/color_quantizer.sv
// RGB888 -> RGB332 streaming encoder with optional 2x2 ordered dither.
// Two-stage valid/ready pipeline (dither+saturate, then quantize); stalls hold all state.
module color_quantizer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DITHER   = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sof,
  input  logic [7:0] in_red,
  input  logic [7:0] in_green,
  input  logic [7:0] in_blue,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic [7:0] out_pixel
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_s1_vld;
  logic              r_s1_sof;
  logic [7:0]        r_s1_r;
  logic [7:0]        r_s1_g;
  logic [7:0]        r_s1_b;
  logic              r_out_vld;
  logic              r_out_sof;
  logic [7:0]        r_out_pixel;

  logic              w_adv;
  logic              w_acc;
  logic [XW-1:0]     w_bx;
  logic [YW-1:0]     w_by;
  logic [XW-1:0]     w_nx;
  logic [YW-1:0]     w_ny;
  logic [1:0]        w_key;
  logic signed [9:0] w_off_rg;
  logic signed [9:0] w_off_b;
  logic [2:0]        w_r3;
  logic [2:0]        w_g3;
  logic [1:0]        w_b2;

  function automatic logic [7:0] sat(input logic [7:0] c, input logic signed [9:0] off);
    logic signed [9:0] s;
    s = $signed({2'b00, c}) + off;
    if (s < 10'sd0)
      return 8'd0;
    else if (s > 10'sd255)
      return 8'd255;
    else
      return s[7:0];
  endfunction

  assign w_adv    = !r_out_vld || out_ready;
  assign w_acc    = in_valid && w_adv;
  assign in_ready = w_adv;

  // A start-of-frame beat is pinned to (0,0) regardless of where the counters were.
  assign w_bx  = in_sof ? '0 : r_x;
  assign w_by  = in_sof ? '0 : r_y;
  assign w_key = {w_by[0], w_bx[0]};

  always_comb begin
    w_nx = w_bx + 1'b1;
    w_ny = w_by;
    if (w_bx == X_LAST) begin
      w_nx = '0;
      w_ny = (w_by == Y_LAST) ? '0 : w_by + 1'b1;
    end
  end

  always_comb begin
    w_off_rg = 10'sd0;
    w_off_b  = 10'sd0;
    if (DITHER != 0) begin
      case (w_key)
        2'b00:   begin w_off_rg = -10'sd12; w_off_b = -10'sd24; end
        2'b01:   begin w_off_rg =  10'sd4;  w_off_b =  10'sd8;  end
        2'b10:   begin w_off_rg =  10'sd12; w_off_b =  10'sd24; end
        default: begin w_off_rg = -10'sd4;  w_off_b = -10'sd8;  end
      endcase
    end
  end

  // Round-to-nearest scaling that maps each display level back to its own index.
  assign w_r3 = 3'(({3'b000, r_s1_r} * 11'd7 + 11'd128) >> 8);
  assign w_g3 = 3'(({3'b000, r_s1_g} * 11'd7 + 11'd128) >> 8);
  assign w_b2 = 2'(({3'b000, r_s1_b} * 11'd3 + 11'd128) >> 8);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_r      <= 8'd0;
      r_s1_g      <= 8'd0;
      r_s1_b      <= 8'd0;
      r_out_vld   <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_pixel <= 8'd0;
    end else if (w_adv) begin
      r_s1_vld    <= in_valid;
      r_s1_sof    <= in_sof;
      r_s1_r      <= sat(in_red,   w_off_rg);
      r_s1_g      <= sat(in_green, w_off_rg);
      r_s1_b      <= sat(in_blue,  w_off_b);
      r_out_vld   <= r_s1_vld;
      r_out_sof   <= r_s1_vld && r_s1_sof;
      r_out_pixel <= {w_r3, w_g3, w_b2};
      if (w_acc) begin
        r_x <= w_nx;
        r_y <= w_ny;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_sof   = r_out_sof;
  assign out_pixel = r_out_pixel;

endmodule

// File: tb/tb_color_quantizer.sv
// Directed bench: dut0 plain rounding at full size, dut1 dithered on a 4x2 raster.
module tb_color_quantizer;

  logic            clk;
  logic [1:0]      rst, inv, ins, ordy, irdy, ovld, osof;
  logic [1:0][7:0] inr, ing, inb, opix;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] L8 [8] = '{8'd0, 8'd36, 8'd73, 8'd109, 8'd146, 8'd182, 8'd220, 8'd255};
  logic [7:0] L4 [4] = '{8'd0, 8'd85, 8'd170, 8'd255};

  logic [7:0] vr[$], vg[$], vb[$];
  logic       vs[$];
  logic [8:0] ve[$];
  logic [8:0] oq0[$], oq1[$];

  color_quantizer dut0 (
    .Clk(clk), .Reset(rst[0]), .in_valid(inv[0]), .in_ready(irdy[0]), .in_sof(ins[0]),
    .in_red(inr[0]), .in_green(ing[0]), .in_blue(inb[0]), .out_valid(ovld[0]),
    .out_ready(ordy[0]), .out_sof(osof[0]), .out_pixel(opix[0]));

  color_quantizer #(.H_ACTIVE(4), .V_ACTIVE(2), .DITHER(1)) dut1 (
    .Clk(clk), .Reset(rst[1]), .in_valid(inv[1]), .in_ready(irdy[1]), .in_sof(ins[1]),
    .in_red(inr[1]), .in_green(ing[1]), .in_blue(inb[1]), .out_valid(ovld[1]),
    .out_ready(ordy[1]), .out_sof(osof[1]), .out_pixel(opix[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ovld[0] && ordy[0]) oq0.push_back({osof[0], opix[0]});
    if (ovld[1] && ordy[1]) oq1.push_back({osof[1], opix[1]});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    vr.delete(); vg.delete(); vb.delete(); vs.delete(); ve.delete();
    oq0.delete(); oq1.delete();
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic s, input logic [8:0] e);
    vr.push_back(r); vg.push_back(g); vb.push_back(b); vs.push_back(s); ve.push_back(e);
  endtask

  // Drives the queued beats; out_ready is dropped for cycles [st, st+sl).
  task automatic stream(input int d, input int st, input int sl);
    int idx = 0;
    int cyc = 0;
    logic [7:0] held = 8'd0;
    while (idx < vr.size() && cyc < 300) begin
      inv[d] = 1'b1; inr[d] = vr[idx]; ing[d] = vg[idx]; inb[d] = vb[idx]; ins[d] = vs[idx];
      ordy[d] = !(cyc >= st && cyc < st + sl);
      @(negedge clk);
      if (cyc == st) held = opix[d];
      if (cyc >= st && cyc < st + sl) begin
        chk("stall_vld", 32'(ovld[d]), 32'd1);
        chk("stall_in_ready", 32'(irdy[d]), 32'd0);
      end
      if (cyc > st && cyc < st + sl) chk("stall_hold", 32'(opix[d]), 32'(held));
      if (irdy[d]) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    if (idx < vr.size()) chk("stream_timeout", 32'(idx), 32'(vr.size()));
    inv[d] = 1'b0; ins[d] = 1'b0; ordy[d] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare(input int d, input string tag);
    logic [8:0] got[$];
    if (d == 0) got = oq0; else got = oq1;
    chk({tag, "_count"}, 32'(got.size()), 32'(ve.size()));
    for (int i = 0; i < ve.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(ve[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 2'b11; inv = '0; ins = '0; ordy = 2'b11;
    inr = '0; ing = '0; inb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid0", 32'(ovld[0]), 32'd0);
    chk("rst_out_pixel0", 32'(opix[0]), 32'd0);
    chk("rst_out_sof0",   32'(osof[0]), 32'd0);
    chk("rst_in_ready0",  32'(irdy[0]), 32'd1);
    chk("rst_out_valid1", 32'(ovld[1]), 32'd0);
    chk("rst_in_ready1",  32'(irdy[1]), 32'd1);
    @(posedge clk); #1;
    rst = 2'b00;

    // latency: accepted on edge A, still invalid after A, valid after B
    inv[0] = 1'b1; inr[0] = 8'd255; ing[0] = 8'd255; inb[0] = 8'd255;
    @(negedge clk);
    chk("lat_in_ready", 32'(irdy[0]), 32'd1);
    @(posedge clk); #1;
    inv[0] = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(ovld[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(ovld[0]), 32'd1);
    chk("lat_cycle2_pixel", 32'(opix[0]), 32'hFF);
    @(posedge clk); #1;

    // every mapper level returns its index
    clr();
    for (int i = 0; i < 8; i++)
      add(L8[i], L8[7-i], L4[i%4], i == 0, {i == 0, 3'(i), 3'(7-i), 2'(i%4)});
    add(8'd220, 8'd109, 8'd170, 1'b0, {1'b0, 8'hCE});
    stream(0, 1000, 0);
    compare(0, "levels");

    // rounding thresholds
    clr();
    add(8'd18, 8'd0, 8'd42, 1'b0, {1'b0, 8'h00});
    add(8'd19, 8'd0, 8'd43, 1'b0, {1'b0, 8'h21});
    add(8'd0, 8'd19, 8'd0, 1'b0, {1'b0, 8'h04});
    stream(0, 1000, 0);
    compare(0, "round");

    // backpressure mid-stream
    clr();
    for (int i = 1; i <= 5; i++)
      add(L8[i], L8[i], L4[i%4], 1'b0, {1'b0, 3'(i), 3'(i), 2'(i%4)});
    stream(0, 2, 3);
    compare(0, "bp");

    // dithered low saturation at (0,0)
    clr();
    add(8'd0, 8'd0, 8'd0, 1'b1, {1'b1, 8'h00});
    stream(1, 1000, 0);
    compare(1, "dith_sat0");

    // dither pattern over a full 4x2 frame plus wrap; (0,1) saturates high
    clr();
    add(8'd128, 8'd128, 8'd128, 1'b1, {1'b1, 8'h6D});
    add(8'd128, 8'd128, 8'd128, 1'b0, {1'b0, 8'h92});
    add(8'd128, 8'd128, 8'd128, 1'b0, {1'b0, 8'h6D});
    add(8'd128, 8'd128, 8'd128, 1'b0, {1'b0, 8'h92});
    add(8'd250, 8'd250, 8'd240, 1'b0, {1'b0, 8'hFF});
    add(8'd128, 8'd128, 8'd128, 1'b0, {1'b0, 8'h6D});
    add(8'd128, 8'd128, 8'd128, 1'b0, {1'b0, 8'h92});
    add(8'd128, 8'd128, 8'd128, 1'b0, {1'b0, 8'h6D});
    add(8'd128, 8'd128, 8'd128, 1'b0, {1'b0, 8'h6D});
    stream(1, 1000, 0);
    compare(1, "dith_wrap");

    // reset with two beats in flight; position counters sit at (3,0) before it
    ordy[1] = 1'b0; inv[1] = 1'b1; ins[1] = 1'b0;
    inr[1] = 8'd128; ing[1] = 8'd128; inb[1] = 8'd128;
    repeat (2) @(posedge clk);
    #1;
    inv[1] = 1'b0;
    @(negedge clk);
    chk("inflight_valid", 32'(ovld[1]), 32'd1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(ovld[1]), 32'd0);
    chk("midrst_out_pixel", 32'(opix[1]), 32'd0);
    chk("midrst_in_ready",  32'(irdy[1]), 32'd1);
    @(posedge clk); #1;
    clr();
    add(8'd128, 8'd128, 8'd128, 1'b0, {1'b0, 8'h6D});
    stream(1, 1000, 0);
    compare(1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
